// File: rtl/csa_resolve.sv
// Multi-cycle carry-propagate resolver: folds a CSA sum/carry pair into one
// two's-complement word, resolving one SEG-bit slice per clock.
module csa_resolve #(
   parameter int WIDTH = 49,
   parameter int SEG   = 13
) (
   input  logic             Clk_CI,
   input  logic             Rst_RBI,
   input  logic             Flush_SI,
   input  logic             In_Valid_SI,
   output logic             In_Ready_SO,
   input  logic [WIDTH-1:0] Sum_DI,
   input  logic [WIDTH-1:0] Carry_DI,
   output logic             Out_Valid_SO,
   input  logic             Out_Ready_SI,
   output logic [WIDTH:0]   Result_DO,
   output logic             Ovf_SO,
   output logic             Zero_SO
);

   localparam int RW   = WIDTH + 1;
   localparam int NSEG = (RW + SEG - 1) / SEG;
   localparam int PW   = NSEG * SEG;
   localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int IW   = $clog2(PW + 1);
   localparam logic [KW-1:0] K_LAST   = KW'(NSEG - 1);
   localparam logic [PW-1:0] SEG_MASK = PW'({SEG{1'b1}});

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] a_q, a_d;
   logic [RW-1:0] b_q, b_d;
   logic [RW-1:0] res_q, res_d;
   logic [KW-1:0] k_q, k_d;
   logic          cin_q, cin_d;
   logic          ovf_q, ovf_d;
   logic          rdy_q, rdy_d;
   logic          vld_q, vld_d;

   logic [PW-1:0] a_pad_s;
   logic [PW-1:0] b_pad_s;
   logic [IW-1:0] base_s;
   logic [SEG:0]  slice_s;
   logic [PW-1:0] merged_s;
   logic [PW:0]   chain_s;

   function automatic logic [SEG:0] slice_add(input logic [SEG-1:0] x,
                                              input logic [SEG-1:0] y,
                                              input logic           c);
      slice_add = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
   endfunction

   assign a_pad_s = PW'(a_q);
   assign b_pad_s = PW'(b_q);

   // Slice datapath, next-state and next-output logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      k_d     = k_q;
      cin_d   = cin_q;
      ovf_d   = ovf_q;

      base_s   = IW'(k_q) * IW'(SEG);
      slice_s  = slice_add(SEG'(a_pad_s >> base_s), SEG'(b_pad_s >> base_s), cin_q);
      merged_s = (PW'(res_q) & ~(SEG_MASK << base_s)) | (PW'(slice_s[SEG-1:0]) << base_s);
      // Padded bits above WIDTH are zero in both operands, so at most one of
      // the chain bits from RW upward can be set: the true carry out of bit WIDTH.
      chain_s  = {slice_s[SEG], merged_s};

      if (Flush_SI) begin
         state_d = IDLE;
         res_d   = '0;
         ovf_d   = 1'b0;
         k_d     = '0;
         cin_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (In_Valid_SI && rdy_q) begin
                  a_d     = {1'b0, Sum_DI};
                  b_d     = {Carry_DI, 1'b0};
                  k_d     = '0;
                  cin_d   = 1'b0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               res_d = chain_s[RW-1:0];
               cin_d = slice_s[SEG];
               k_d   = k_q + KW'(1);
               if (k_q == K_LAST) begin
                  ovf_d   = |chain_s[PW:RW];
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
            DONE: begin
               if (Out_Ready_SI) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      rdy_d = (state_d == IDLE);
      vld_d = (state_d == DONE);
   end

   // State, operand and result registers
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         k_q     <= '0;
         cin_q   <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         k_q     <= k_d;
         cin_q   <= cin_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
         vld_q   <= vld_d;
      end
   end

   assign In_Ready_SO  = rdy_q;
   assign Out_Valid_SO = vld_q;
   assign Result_DO    = res_q;
   assign Ovf_SO       = ovf_q;
   assign Zero_SO      = (res_q == '0);

endmodule

// File: tb/tb_csa_resolve.sv
// Scoreboard bench for csa_resolve: directed corner cases plus randomized
// traffic, run concurrently on four instances with different slice widths.
module tb_csa_resolve;

   localparam int W      = 49;
   localparam int RW     = W + 1;
   localparam int NDUT   = 4;
   localparam int NRAND  = 400;
   localparam int MAXCYC = 90000;

   typedef struct packed {
      logic [RW-1:0] res;
      logic          ovf;
      logic [31:0]   acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_done = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer addition of the two operands at their weights.
   function automatic logic [RW:0] ref_add(input logic [W-1:0] s, input logic [W-1:0] c);
      logic [RW:0] full;
      full = {2'b00, s} + {1'b0, c, 1'b0};
      return full;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(64'd1 << $urandom_range(0, W - 1));
         default: return r[W-1:0];
      endcase
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : g_inst
      localparam int SEG      = (g == 0) ? 13 : (g == 1) ? 1 : (g == 2) ? 7 : 50;
      localparam int NSEG     = (RW + SEG - 1) / SEG;
      localparam int FLUSH_AT = (NSEG > 2) ? 2 : 0;

      logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, ovf, zero;
      logic [W-1:0]  sum, carry;
      logic [RW-1:0] result;
      int            cyc = 0;
      exp_t          q[$];
      bit            seen = 1'b0;
      string         tag;

      csa_resolve #(.WIDTH(W), .SEG(SEG)) u_dut (
         .Clk_CI       (clk),
         .Rst_RBI      (rst_n),
         .Flush_SI     (flush),
         .In_Valid_SI  (in_valid),
         .In_Ready_SO  (in_ready),
         .Sum_DI       (sum),
         .Carry_DI     (carry),
         .Out_Valid_SO (out_valid),
         .Out_Ready_SI (out_ready),
         .Result_DO    (result),
         .Ovf_SO       (ovf),
         .Zero_SO      (zero)
      );

      always @(posedge clk) cyc <= cyc + 1;

      task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
         int t;
         in_valid = 1'b1;
         sum      = s;
         carry    = c;
         t = 0;
         while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (t >= 400) chk({tag, " send_timeout"}, 64'(in_ready), 64'd1);
         @(negedge clk);
         in_valid = 1'b0;
      endtask

      task automatic wait_valid();
         int t;
         t = 0;
         while (!out_valid && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (!out_valid) chk({tag, " valid_timeout"}, 64'(out_valid), 64'd1);
      endtask

      // Monitor: samples after the driver has settled, pops and compares
      initial begin : mon
         exp_t        cur;
         logic [RW:0] m;
         cur = '0;
         forever begin
            @(negedge clk);
            #2;
            if (!rst_n || flush) begin
               q.delete();
               seen = 1'b0;
            end else begin
               if (out_valid) begin
                  if (!seen) begin
                     if (q.size() == 0) begin
                        chk({tag, " unexpected_out_valid"}, 64'(out_valid), 64'd0);
                     end else begin
                        cur = q.pop_front();
                        chk({tag, " result"}, 64'(result), 64'(cur.res));
                        chk({tag, " ovf"}, 64'(ovf), 64'(cur.ovf));
                        chk({tag, " zero"}, 64'(zero), 64'(cur.res == '0));
                        chk({tag, " latency"}, 64'(cyc - int'(cur.acc)), 64'(NSEG));
                        seen = 1'b1;
                     end
                  end else begin
                     chk({tag, " result_hold"}, 64'(result), 64'(cur.res));
                  end
                  chk({tag, " in_ready_in_done"}, 64'(in_ready), 64'd0);
                  if (out_ready) seen = 1'b0;
               end
               if (in_valid && in_ready) begin
                  m = ref_add(sum, carry);
                  q.push_back('{res: m[RW-1:0], ovf: m[RW], acc: 32'(cyc + 1)});
               end
            end
         end
      end

      initial begin : drv
         logic [RW:0]  m;
         logic [W-1:0] s, c;
         int           acc_n, t;
         tag       = $sformatf("seg%0d", SEG);
         rst_n     = 1'b0;
         flush     = 1'b0;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         sum       = '0;
         carry     = '0;
         repeat (3) @(negedge clk);
         chk({tag, " rst_in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, " rst_out_valid"}, 64'(out_valid), 64'd0);
         chk({tag, " rst_result"}, 64'(result), 64'd0);
         chk({tag, " rst_ovf"}, 64'(ovf), 64'd0);
         chk({tag, " rst_zero"}, 64'(zero), 64'd1);
         rst_n = 1'b1;
         @(negedge clk);
         chk({tag, " post_rst_in_ready"}, 64'(in_ready), 64'd1);

         send('0, '0);
         wait_valid();
         chk({tag, " zero_op_result"}, 64'(result), 64'd0);
         chk({tag, " zero_op_zero"}, 64'(zero), 64'd1);
         chk({tag, " zero_op_ovf"}, 64'(ovf), 64'd0);
         @(negedge clk);

         send({W{1'b1}}, 49'h1);
         wait_valid();
         chk({tag, " ripple_result"}, 64'(result), 64'h2_0000_0000_0001);
         chk({tag, " ripple_ovf"}, 64'(ovf), 64'd0);
         chk({tag, " ripple_zero"}, 64'(zero), 64'd0);
         @(negedge clk);

         send({W{1'b1}}, {W{1'b1}});
         wait_valid();
         chk({tag, " ones_result"}, 64'(result), 64'h1_FFFF_FFFF_FFFD);
         chk({tag, " ones_ovf"}, 64'(ovf), 64'd1);
         @(negedge clk);

         // Backpressure: result must hold and no capture may occur
         out_ready = 1'b0;
         s = rnd_op();
         c = rnd_op();
         m = ref_add(s, c);
         send(s, c);
         wait_valid();
         for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            sum      = rnd_op();
            carry    = rnd_op();
            @(negedge clk);
            chk({tag, " bp_out_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " bp_in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, " bp_result"}, 64'(result), 64'(m[RW-1:0]));
            chk({tag, " bp_ovf"}, 64'(ovf), 64'(m[RW]));
         end
         out_ready = 1'b1;
         @(negedge clk);
         chk({tag, " bp_release_in_ready"}, 64'(in_ready), 64'd1);
         chk({tag, " bp_release_out_valid"}, 64'(out_valid), 64'd0);
         chk({tag, " idle_result_hold"}, 64'(result), 64'(m[RW-1:0]));
         @(negedge clk);
         chk({tag, " bp_next_accept"}, 64'(in_ready), 64'd0);
         in_valid = 1'b0;
         wait_valid();
         @(negedge clk);

         // Flush mid-RUN
         send(rnd_op() | 49'h1, rnd_op());
         repeat (FLUSH_AT) @(negedge clk);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         chk({tag, " flush_in_ready"}, 64'(in_ready), 64'd1);
         chk({tag, " flush_out_valid"}, 64'(out_valid), 64'd0);
         chk({tag, " flush_result"}, 64'(result), 64'd0);
         chk({tag, " flush_zero"}, 64'(zero), 64'd1);
         chk({tag, " flush_ovf"}, 64'(ovf), 64'd0);
         repeat (NSEG + 2) begin
            @(negedge clk);
            chk({tag, " flush_no_valid"}, 64'(out_valid), 64'd0);
         end
         send(rnd_op(), rnd_op());
         wait_valid();
         @(negedge clk);

         // Reset mid-RUN
         send({W{1'b1}}, {W{1'b1}});
         repeat (FLUSH_AT) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         chk({tag, " mrst_in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, " mrst_out_valid"}, 64'(out_valid), 64'd0);
         chk({tag, " mrst_result"}, 64'(result), 64'd0);
         chk({tag, " mrst_zero"}, 64'(zero), 64'd1);
         rst_n = 1'b1;
         @(negedge clk);
         chk({tag, " mrst_release_in_ready"}, 64'(in_ready), 64'd1);
         repeat (NSEG + 2) begin
            @(negedge clk);
            chk({tag, " mrst_no_valid"}, 64'(out_valid), 64'd0);
         end
         send(rnd_op(), rnd_op());
         wait_valid();
         @(negedge clk);

         // Randomized traffic with random consumer backpressure
         acc_n = 0;
         t     = 0;
         while (acc_n < NRAND && t < MAXCYC) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sum       = rnd_op();
            carry     = rnd_op();
            if (in_valid && in_ready) acc_n++;
            @(negedge clk);
            t++;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         if (acc_n < NRAND) chk({tag, " random_budget"}, 64'(acc_n), 64'(NRAND));
         t = 0;
         while ((q.size() != 0 || out_valid) && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (t >= 400) chk({tag, " drain_timeout"}, 64'(out_valid), 64'd0);
         n_done++;
      end
   end

   initial begin : fin
      int t;
      t = 0;
      while (n_done < NDUT && t < 99000) begin
         @(negedge clk);
         t++;
      end
      if (n_done < NDUT) begin
         n_cmp++;
         n_err++;
         $display("FAIL global_timeout: finished=%0d required=%0d", n_done, NDUT);
      end
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
